// File: rtl/alu_pkg.sv
// Shared constants for the RV32I ALU: opcode and funct3 fields, ALU operation encoding,
// and the funct3-to-operation decode used by both register and immediate arithmetic.
package alu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRA    = 4'd8,
        ALU_SRL    = 4'd9,
        ALU_COPY_B = 4'd10,
        ALU_XXX    = 4'd15
    } alu_op_e;

    // Immediate forms have no SUB: bit 30 there is part of the immediate, so allow_sub gates it.
    function automatic alu_op_e decode_funct(input logic [2:0] funct, input logic alt,
                                             input logic allow_sub);
        alu_op_e op;
        case (funct)
            F3_ADD:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_opdec.sv
// Combinational decoder from RV32I opcode/funct3/bit30 to the ALU operation code.
module alu_opdec
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct,
    input  logic       add_rshift_type,
    output logic [3:0] ALUop
);

    alu_op_e op;

    always_comb begin
        op = ALU_XXX;
        case (opcode)
            OPC_LUI:    op = ALU_COPY_B;
            OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE:
                        op = ALU_ADD;
            OPC_OP:     op = decode_funct(funct, add_rshift_type, 1'b1);
            OPC_OP_IMM: op = decode_funct(funct, add_rshift_type, 1'b0);
            default:    op = ALU_XXX;
        endcase
    end

    assign ALUop = op;

endmodule

// File: rtl/alu_dec.sv
// RV32I ALU with combinational operation decode and a single registered result.
module alu_dec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct,
    input  logic            add_rshift_type,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [3:0]      ALUop,
    output logic [XLEN-1:0] Out
);

    logic [XLEN-1:0] result;
    logic [4:0]      shamt;

    alu_opdec u_opdec (
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .ALUop           (ALUop)
    );

    assign shamt = B[4:0];

    always_comb begin
        result = '0;
        case (ALUop)
            ALU_ADD:    result = A + B;
            ALU_SUB:    result = A - B;
            ALU_AND:    result = A & B;
            ALU_OR:     result = A | B;
            ALU_XOR:    result = A ^ B;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (A < B)};
            ALU_SLL:    result = A << shamt;
            ALU_SRA:    result = $signed(A) >>> shamt;
            ALU_SRL:    result = A >> shamt;
            ALU_COPY_B: result = B;
            default:    result = '0;
        endcase
    end

    // Reset only clears the result register; the decoder stays live throughout.
    always_ff @(posedge clk) begin
        if (reset) begin
            Out <= '0;
        end else begin
            Out <= result;
        end
    end

endmodule

// File: tb/tb_alu_dec.sv
// Self-checking bench for alu_dec: directed vectors plus a random sweep against a
// reference model, with expected results queued at drive time and popped after the edge.
module tb_alu_dec;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] Out;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    alu_dec #(.XLEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .A               (A),
        .B               (B),
        .ALUop           (ALUop),
        .Out             (Out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] modelOp(input logic [6:0] op, input logic [2:0] f, input logic r);
        if (op == 7'b0110111) return 4'd10;
        if (op == 7'b0010111 || op == 7'b1101111 || op == 7'b1100111 ||
            op == 7'b1100011 || op == 7'b0000011 || op == 7'b0100011) return 4'd0;
        if (op != 7'b0110011 && op != 7'b0010011) return 4'd15;
        if (f == 3'd0) return (r && op == 7'b0110011) ? 4'd1 : 4'd0;
        if (f == 3'd1) return 4'd7;
        if (f == 3'd2) return 4'd5;
        if (f == 3'd3) return 4'd6;
        if (f == 3'd4) return 4'd4;
        if (f == 3'd5) return r ? 4'd8 : 4'd9;
        if (f == 3'd6) return 4'd3;
        return 4'd2;
    endfunction

    function automatic logic [31:0] modelOut(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh  = int'(b & 32'd31);
        ext = {{32{a[31]}}, a};
        if (op == 4'd0) return a + b;
        if (op == 4'd1) return a + ~b + 32'd1;
        if (op == 4'd2) return a & b;
        if (op == 4'd3) return a | b;
        if (op == 4'd4) return a ^ b;
        if (op == 4'd5) begin
            if (a[31] != b[31]) return {31'd0, a[31]};
            return {31'd0, (a < b)};
        end
        if (op == 4'd6) return {31'd0, (a < b)};
        if (op == 4'd7) return a << sh;
        if (op == 4'd8) begin
            ext = ext >> sh;
            return ext[31:0];
        end
        if (op == 4'd9) return a >> sh;
        if (op == 4'd10) return b;
        return 32'd0;
    endfunction

    // Drive away from the active edge, check the decode, queue the result, then check it after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic [6:0] op,
                                 input logic [2:0] f, input logic r,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] exp_op, input logic [31:0] exp_out);
        logic [31:0] e;
        @(negedge clk);
        reset = rst;
        opcode = op;
        funct = f;
        add_rshift_type = r;
        A = a;
        B = b;
        #1;
        checkOutput({tag, "_aluop"}, {28'd0, ALUop}, {28'd0, exp_op});
        exp_q.push_back(exp_out);
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({tag, "_out"}, Out, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0]  ops [11];
        logic [6:0]  op;
        logic [2:0]  f;
        logic        r;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  eop;

        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011};

        reset = 1'b1;
        opcode = 7'b0110011;
        funct = 3'd0;
        add_rshift_type = 1'b0;
        A = 32'd0;
        B = 32'd0;

        $display("[TB] starting alu_dec bench");

        applyStimulus("reset_hold", 1'b1, 7'b0110011, 3'd0, 1'b0, 32'h3, 32'h4, 4'd0, 32'h0);
        applyStimulus("sub",        1'b0, 7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 4'd1, 32'hFFFFFFFE);
        applyStimulus("addi_bit30", 1'b0, 7'b0010011, 3'd0, 1'b1, 32'h10, 32'h20, 4'd0, 32'h30);
        applyStimulus("sra",        1'b0, 7'b0110011, 3'd5, 1'b1, 32'h80000000, 32'h24, 4'd8, 32'hF8000000);
        applyStimulus("srl",        1'b0, 7'b0110011, 3'd5, 1'b0, 32'h80000000, 32'h24, 4'd9, 32'h08000000);
        applyStimulus("sll_zero",   1'b0, 7'b0110011, 3'd1, 1'b0, 32'h89ABCDEF, 32'h20, 4'd7, 32'h89ABCDEF);
        applyStimulus("slt",        1'b0, 7'b0110011, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd5, 32'd1);
        applyStimulus("sltu",       1'b0, 7'b0110011, 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd6, 32'd0);
        applyStimulus("xor",        1'b0, 7'b0110011, 3'd4, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'h0FF00FF0);
        applyStimulus("or",         1'b0, 7'b0010011, 3'd6, 1'b1, 32'hF0000000, 32'h0000000F, 4'd3, 32'hF000000F);
        applyStimulus("and",        1'b0, 7'b0110011, 3'd7, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000);
        applyStimulus("lui",        1'b0, 7'b0110111, 3'd3, 1'b1, 32'h1234, 32'hABCDE000, 4'd10, 32'hABCDE000);
        applyStimulus("illegal",    1'b0, 7'b1111111, 3'd0, 1'b0, 32'h5, 32'h6, 4'd15, 32'h0);
        applyStimulus("jal_add",    1'b0, 7'b1101111, 3'd5, 1'b1, 32'hFFFFFFFF, 32'd2, 4'd0, 32'd1);
        applyStimulus("reset_mid",  1'b1, 7'b0110011, 3'd0, 1'b0, 32'h100, 32'h23, 4'd0, 32'h0);
        applyStimulus("reset_exit", 1'b0, 7'b0110011, 3'd0, 1'b0, 32'h100, 32'h23, 4'd0, 32'h123);

        for (int i = 0; i < 130; i++) begin
            int idx;
            idx = int'($urandom_range(0, 11));
            op  = (idx == 11) ? 7'($urandom) : ops[idx];
            f   = 3'($urandom);
            r   = 1'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            eop = modelOp(op, f, r);
            applyStimulus("sweep", 1'b0, op, f, r, a, b, eop, modelOut(eop, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_dec.md
ALU_DEC -- requirements
Module: alu_dec

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is required to work.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: opcode  input  7  RV32I instruction opcode field.
REQ-005 Port: funct  input  3  RV32I funct3 field.
REQ-006 Port: add_rshift_type  input  1  instruction bit 30; selects SUB vs ADD and SRA vs SRL.
REQ-007 Port: A  input  XLEN  first operand.
REQ-008 Port: B  input  XLEN  second operand, register or immediate.
REQ-009 Port: ALUop  output  4  decoded operation, combinational from opcode/funct/add_rshift_type.
REQ-010 Port: Out  output  XLEN  registered ALU result.

Function
REQ-011 ALUop encoding SHALL be: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRA=8, SRL=9, COPY_B=10, XXX=15.
REQ-012 opcode 0110111 (LUI) SHALL decode to COPY_B.
REQ-013 opcodes 0010111 (AUIPC), 1101111 (JAL), 1100111 (JALR), 1100011 (BRANCH), 0000011 (LOAD), 0100011 (STORE) SHALL decode to ADD, ignoring funct and add_rshift_type.
REQ-014 opcode 0110011 (R-type) SHALL decode funct: 000 ADD, or SUB if add_rshift_type=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if add_rshift_type=1; 110 OR; 111 AND.
REQ-015 opcode 0010011 (I-type) SHALL decode as R-type, except funct 000 is always ADD regardless of add_rshift_type.
REQ-016 Any other opcode SHALL decode to XXX.
REQ-017 ADD/SUB SHALL be modulo 2^32, overflow and carry discarded.
REQ-018 AND/OR/XOR SHALL be bitwise.
REQ-019 SLT SHALL give 1 if A<B signed, else 0.
REQ-020 SLTU SHALL give 1 if A<B unsigned, else 0.
REQ-021 SLL/SRL/SRA SHALL shift A by B[4:0] only; SRA SHALL sign-extend from A[31]; shift 0 returns A.
REQ-022 COPY_B SHALL return B.
REQ-023 XXX and unused encodings (11-14) SHALL return 0.
REQ-024 Out SHALL register the result of the current inputs at each rising clk edge; latency is exactly 1 cycle.
REQ-025 Inputs SHALL NOT be latched; any input change is reflected in Out after the next edge.

Reset
REQ-026 When reset=1 at a rising edge, Out SHALL become 0, overriding the computed result.
REQ-027 ALUop SHALL stay combinational and SHALL NOT be affected by reset.
REQ-028 Deasserting reset mid-stream: the first edge with reset=0 SHALL register the result of the inputs present at that edge.

Structure
REQ-029 A shared package alu_pkg SHALL hold the opcode constants, funct3 constants and the ALUop encoding.
REQ-030 The decoder SHALL be one combinational sub-module alu_opdec; the datapath and Out register SHALL live in alu_dec.
REQ-031 The block SHALL have no state other than the Out register.

Verification
REQ-032 R-type opcode 0110011, funct 000, rshift 1, A=5, B=7 -> ALUop=1, Out=0xFFFFFFFE one cycle later.
REQ-033 I-type opcode 0010011, funct 000, rshift 1, A=0x10, B=0x20 -> ALUop=0 (ADD), Out=0x30.
REQ-034 R-type funct 101, A=0x80000000, B=0x24: rshift 1 -> Out=0xF8000000; rshift 0 -> Out=0x08000000 (shift amount 4).
REQ-035 funct 010 / 011, A=0xFFFFFFFF, B=1 -> SLT Out=1; SLTU Out=0.
REQ-036 LUI opcode 0110111, A=0x1234, B=0xABCDE000 -> Out=0xABCDE000; opcode 1111111 -> ALUop=15, Out=0.
REQ-037 reset=1 with valid ADD inputs -> Out=0 at that edge; a 130-vector random sweep of all opcode/funct combinations SHALL match a reference model with 1-cycle latency.
